// File: rtl/add_stream_ctrl_pkg.sv
// Shared definitions for the add_stream_ctrl slice: size defaults and the
// controller FSM state encoding.
package add_stream_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_WAIT_LO = 3'd2;
  localparam state_t ST_WAIT_HI = 3'd3;
  localparam state_t ST_OUT     = 3'd4;

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers and a registered occupancy count.
// full and empty are decoded from the registered count only, so a pop never makes a full FIFO writable in the same cycle.
module op_fifo
  import add_stream_ctrl_pkg::*;
#(
  parameter int DW    = 2 * DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (fill == (AW + 1)'(DEPTH));
  assign empty    = (fill == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/add_stream_ctrl.sv
// Streams queued operand pairs through an external adder core, one operation at a time, and presents each sum to the output.
// Handshakes: a transfer happens on a clk edge where valid and ready are both high; valid never waits on ready and holds its data until the transfer.
module add_stream_ctrl
  import add_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_a,
  output logic [WIDTH-1:0]         core_b,
  input  logic [WIDTH-1:0]         core_result,
  input  logic                     core_done,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     busy,
  output state_t                   state
);

  logic [2*WIDTH-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign busy     = (state != ST_IDLE);

  op_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  // core_start is registered on the IDLE->ISSUE transition, so it is high exactly while in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            core_a     <= head[2*WIDTH-1:WIDTH];
            core_b     <= head[WIDTH-1:0];
            core_start <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_LO;
        // A done level left over from the previous operation must clear before the new result can be trusted.
        ST_WAIT_LO: begin
          if (!core_done) state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (core_done) begin
            out_data  <= core_result;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_stream_ctrl.sv
// Directed bench for add_stream_ctrl with a behavioural adder core whose done timing is adjustable.
module tb_add_stream_ctrl;
  import add_stream_ctrl_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int FW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          core_start;
  logic [W-1:0]  core_a;
  logic [W-1:0]  core_b;
  logic [W-1:0]  core_result;
  logic          core_done;
  logic [FW-1:0] fill;
  logic          busy;
  state_t        dut_state;

  add_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_result (core_result),
    .core_done   (core_done),
    .fill        (fill),
    .busy        (busy),
    .state       (dut_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  exp_q[$];
  int            start_cnt = 0;
  int            ov_cycles = 0;
  int            results_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural adder core ----------------
  int           stale_hold = 0;
  int           done_delay = 1;
  int           core_phase;
  int           core_cnt;
  logic [W-1:0] core_sum;

  always @(posedge clk) begin
    if (reset) begin
      core_done   <= 1'b0;
      core_result <= '0;
      core_phase  <= 0;
      core_cnt    <= 0;
      core_sum    <= '0;
    end else begin
      case (core_phase)
        0: if (core_start) begin
          core_sum <= core_a + core_b;
          if (stale_hold == 0) begin
            core_done  <= 1'b0;
            core_phase <= 2;
            core_cnt   <= done_delay;
          end else begin
            core_phase <= 1;
            core_cnt   <= stale_hold;
          end
        end
        1: if (core_cnt <= 1) begin
          core_done  <= 1'b0;
          core_phase <= 2;
          core_cnt   <= done_delay;
        end else core_cnt <= core_cnt - 1;
        2: if (core_cnt <= 1) begin
          core_done   <= 1'b1;
          core_result <= core_sum;
          core_phase  <= 0;
        end else core_cnt <= core_cnt - 1;
        default: core_phase <= 0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (core_start) start_cnt++;
      if (out_valid) ov_cycles++;
      if (out_valid && out_ready) begin
        results_seen++;
        if (exp_q.size() == 0) check_eq("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
        else check_eq("sb_out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int   guard = 0;
    logic acc   = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("push_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || fill != '0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, 64'(guard < 1000), 64'd1);
    tick(1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] wa   [9] = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd800, 32'd900};
  logic [W-1:0] wb   [9] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
  logic [W-1:0] wsum [9] = '{32'd101, 32'd202, 32'd303, 32'd404, 32'd505, 32'd606, 32'd707, 32'd808, 32'd909};

  initial begin
    int s0;
    int r0;
    int guard;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check_eq("rst_in_ready",   64'(in_ready),   64'd1);
    check_eq("rst_fill",       64'(fill),       64'd0);
    check_eq("rst_out_valid",  64'(out_valid),  64'd0);
    check_eq("rst_out_data",   64'(out_data),   64'd0);
    check_eq("rst_core_start", 64'(core_start), 64'd0);
    check_eq("rst_core_a",     64'(core_a),     64'd0);
    check_eq("rst_core_b",     64'(core_b),     64'd0);
    check_eq("rst_busy",       64'(busy),       64'd0);
    check_eq("rst_state",      64'(dut_state),  64'(ST_IDLE));
    tick(1);

    // single pair 3+4
    start_cnt = 0;
    ov_cycles = 0;
    exp_q.push_back(32'd7);
    push_pair(32'd3, 32'd4);
    wait_drain("drain_single");
    check_eq("single_start_pulses", 64'(start_cnt),    64'd1);
    check_eq("single_valid_cycles", 64'(ov_cycles),    64'd1);
    check_eq("single_results",      64'(results_seen), 64'd1);
    check_eq("single_busy_after",   64'(busy),         64'd0);

    // five back-to-back pairs fill the FIFO
    r0 = results_seen;
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(2 * i));
    for (int i = 1; i <= 5; i++) push_pair(32'(i), 32'(i));
    @(negedge clk);
    check_eq("burst_fill_full", 64'(fill),     64'd4);
    check_eq("burst_in_ready",  64'(in_ready), 64'd0);
    tick(1);
    wait_drain("drain_burst");
    check_eq("burst_results", 64'(results_seen - r0), 64'd5);

    // stale done from the previous op must be ignored; 0xFFFFFFFF + 1 wraps to 0
    stale_hold = 3;
    done_delay = 2;
    exp_q.push_back(32'd0);
    push_pair(32'hFFFF_FFFF, 32'd1);
    wait_drain("drain_stale");
    stale_hold = 0;
    done_delay = 1;

    // downstream stall with 9 pending; next pair must wait
    out_ready = 1'b0;
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd2);
    push_pair(32'd4, 32'd5);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("stall_valid_seen", 64'(guard < 100), 64'd1);
    tick(1);
    push_pair(32'd1, 32'd1);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_out_valid", 64'(out_valid), 64'd1);
      check_eq("stall_out_data",  64'(out_data),  64'd9);
      check_eq("stall_no_issue",  64'(start_cnt), 64'(s0));
    end
    tick(1);
    out_ready = 1'b1;
    wait_drain("drain_stall");

    // reset in WAIT_HI with two pairs queued
    done_delay = 6;
    r0 = results_seen;
    push_pair(32'd7, 32'd7);
    push_pair(32'd8, 32'd8);
    push_pair(32'd9, 32'd9);
    guard = 0;
    while (!(dut_state == ST_WAIT_HI && fill == FW'(2)) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("midrst_reach_wait_hi", 64'(guard < 50), 64'd1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_fill",      64'(fill),      64'd0);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready",  64'(in_ready),  64'd1);
    check_eq("midrst_busy",      64'(busy),      64'd0);
    repeat (20) @(negedge clk);
    check_eq("midrst_no_result", 64'(results_seen), 64'(r0));
    tick(1);
    done_delay = 1;

    // simultaneous push and pop at fill 2
    out_ready = 1'b0;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd9);
    push_pair(32'd1, 32'd2);
    push_pair(32'd2, 32'd3);
    push_pair(32'd3, 32'd4);
    guard = 0;
    while (!(dut_state == ST_OUT && fill == FW'(2)) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("pp_reach_out", 64'(guard < 50), 64'd1);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    in_valid = 1'b1;
    in_a     = 32'd4;
    in_b     = 32'd5;
    @(negedge clk);
    check_eq("pp_state_idle",  64'(dut_state), 64'(ST_IDLE));
    check_eq("pp_fill_before", 64'(fill),      64'd2);
    check_eq("pp_in_ready",    64'(in_ready),  64'd1);
    tick(1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("pp_fill_after", 64'(fill), 64'd2);
    tick(1);
    wait_drain("drain_pushpop");

    // nine operations through the FIFO exercise pointer wrap
    r0 = results_seen;
    for (int i = 0; i < 9; i++) exp_q.push_back(wsum[i]);
    for (int i = 0; i < 9; i++) push_pair(wa[i], wb[i]);
    wait_drain("drain_wrap");
    check_eq("wrap_results", 64'(results_seen - r0), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
